// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
//
// Purpose: a core store to BASE_ADDR queues one byte into a DEPTH-entry FIFO;
// the TX FSM drains the FIFO and serialises each byte as 8N1 on tx. A status
// word (empty/full/active/overflow/count) is readable at BASE_ADDR+4, and a
// store of bit0=1 there clears the sticky overflow flag.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   store strobe (single cycle)
//   wr_addr  in   store byte address
//   wr_data  in   store data (lane 0 carries the payload)
//   byte_en  in   store byte lanes
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  registered status read data
//   rd_hit   out  registered, high when rd_data belongs to this block
//   tx       out  serial line, idle high
//   busy     out  FIFO non-empty or FSM not idle
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  byte_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        tx,
  output logic        busy
);

  localparam int              AW          = $clog2(DEPTH);
  localparam int              CW          = AW + 1;
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0]     BIT_LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [31:0]   rd_data_q;
  logic          rd_hit_q;

  logic          push_req, push_ok, clr_req, pop;
  logic          empty, full, timer_end;
  logic [7:0]    head;
  logic [31:0]   status;

  // Lanes other than lane 0 carry nothing for this block.
  logic          unused_bits;
  assign unused_bits = ^{wr_data[31:8], byte_en[3:1]};

  assign push_req  = wr_en && (wr_addr == BASE_ADDR) && byte_en[0];
  assign clr_req   = wr_en && (wr_addr == STATUS_ADDR) && byte_en[0] && wr_data[0];
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  // A full FIFO still accepts a push when the FSM frees a slot the same edge.
  assign push_ok   = push_req && (!full || pop);
  assign head      = mem_q[rptr_q];
  assign timer_end = (timer_q == BIT_LAST);

  assign status = {20'b0, 4'(count_q), 4'b0, ovf_q, (state_q != S_IDLE), full, empty};

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_req) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // tx_d anticipates the next state's line level so tx changes on the same
  // edge as the state transition while still coming straight from a flop.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          timer_d = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (timer_end) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_end) begin
          timer_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      rd_hit_q  <= (rd_addr == STATUS_ADDR);
      rd_data_q <= (rd_addr == STATUS_ADDR) ? status : 32'h0;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wr_data[7:0];
    end
  end

  assign tx      = tx_q;
  assign busy    = !empty || (state_q != S_IDLE);
  assign rd_data = rd_data_q;
  assign rd_hit  = rd_hit_q;

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000: byte address of the TX data register; the status register is at BASE_ADDR+4.
REQ-002 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter DEPTH, default 8: TX FIFO entries; must be a power of 2, at least 2.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  core data-port store strobe, single-cycle.
REQ-007 wr_addr  input  32  store byte address.
REQ-008 wr_data  input  32  store data.
REQ-009 byte_en  input  4  store byte lanes; bit 0 selects wr_data[7:0].
REQ-010 rd_addr  input  32  core data-port read address, sampled every cycle.
REQ-011 rd_data  output  32  status read data, registered.
REQ-012 rd_hit  output  1  registered; high when rd_data is valid for this block.
REQ-013 tx  output  1  serial line, 8N1, idle high.
REQ-014 busy  output  1  high when the FIFO is non-empty or the TX FSM is not IDLE.

Function
REQ-015 A data push request occurs when wr_en=1, wr_addr==BASE_ADDR and byte_en[0]=1; wr_data[7:0] is the payload and other lanes are ignored.
REQ-016 A push request with FIFO not full writes the entry at the write pointer and increments the count in the same edge.
REQ-017 A push request with FIFO full drops the byte and sets the sticky overflow flag; FIFO contents are unchanged.
REQ-018 A store to BASE_ADDR+4 with byte_en[0]=1 and wr_data[0]=1 clears overflow; if the same cycle also overflows, overflow ends set (set wins).
REQ-019 Stores to any other address, or with byte_en[0]=0, have no effect.
REQ-020 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-021 Pop and push in the same cycle: count is unchanged. A push while full is accepted if a pop occurs that cycle. A pop requires count>0 before the edge, so a byte pushed into an empty FIFO is not popped that cycle.
REQ-022 Status word: bit0 empty, bit1 full, bit2 FSM not IDLE, bit3 overflow, bits[11:8] count (zero-extended or truncated to 4 bits), all other bits 0.
REQ-023 When rd_addr==BASE_ADDR+4, the next edge loads rd_data with the status word sampled before the edge and sets rd_hit=1; otherwise rd_hit=0 and rd_data=0.
REQ-024 A read of BASE_ADDR returns rd_hit=0; the data register is write-only.
REQ-025 TX FSM states: IDLE, START, DATA, STOP, with a bit-timer 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-026 IDLE: tx=1; if count>0, pop the head into the shift register, clear the timer and go to START.
REQ-027 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-028 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first; shift right after each bit; after bit 7 go to STOP.
REQ-029 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, if count>0, pop and go directly to START, else go to IDLE.
REQ-030 A frame is exactly 10*CLKS_PER_BIT cycles of tx. The START edge follows the pop edge by 0 cycles; tx is driven from a register.
REQ-031 FIFO writes never disturb a frame in progress.

Reset
REQ-032 rst_n=0 asynchronously forces: FSM=IDLE, tx=1, pointers=0, count=0, overflow=0, timer=0, bit index=0, rd_data=0, rd_hit=0, busy=0.
REQ-033 Reset mid-frame aborts the frame; tx returns high immediately and the FIFO contents are discarded.
REQ-034 The first push may occur on the first rising edge after rst_n deasserts.

Verification
REQ-035 CLKS_PER_BIT=4: store 0x55 to BASE_ADDR with byte_en=4'b0001 -> after 1 cycle tx low for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; busy low after 40 cycles.
REQ-036 Three back-to-back stores 0x01, 0x02, 0x03 -> three contiguous 40-cycle frames with no idle gap between them.
REQ-037 DEPTH=8: 10 stores while the first frame is in progress -> 9 accepted (1 popped plus 8 queued), 1 dropped; status = full=1, overflow=1, count=8.
REQ-038 Store 0x1 to BASE_ADDR+4 -> overflow=0. A same-cycle clear and overflow push -> overflow=1.
REQ-039 rd_addr=BASE_ADDR+4 when idle and empty -> next cycle rd_hit=1, rd_data=32'h0000_0001. rd_addr=BASE_ADDR+8 -> rd_hit=0, rd_data=0.
REQ-040 rst_n pulsed low during DATA -> tx=1 and busy=0 without waiting for an edge; a new store afterward transmits correctly.
